// File: rtl/demux_1_2_stream.sv
// 1:2 registered stream demultiplexer; packets are locked to the output chosen on their first beat.
// Optional delivered-beat counters on both outputs when DEMUX_CNT_EN is defined.
module demux_1_2_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] m0_data,
    output logic             m0_last,
    output logic             m0_valid,
    input  logic             m0_ready,
    output logic [WIDTH-1:0] m1_data,
    output logic             m1_last,
    output logic             m1_valid,
    input  logic             m1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]      m0_cnt,
    output logic [15:0]      m1_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

    state_e state;
    logic   target;
    logic   free0;
    logic   free1;
    logic   accept;
    logic   load0;
    logic   load1;

    // sel only matters on the first beat of a packet
    assign target  = (state == StIdle) ? sel : (state == StLock1);
    assign free0   = !m0_valid || m0_ready;
    assign free1   = !m1_valid || m1_ready;
    assign s_ready = target ? free1 : free0;
    assign accept  = s_valid && s_ready;
    assign load0   = accept && !target;
    assign load1   = accept && target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            m0_valid <= 1'b0;
            m0_data  <= '0;
            m0_last  <= 1'b0;
            m1_valid <= 1'b0;
            m1_data  <= '0;
            m1_last  <= 1'b0;
        end else begin
            if (load0) begin
                m0_valid <= 1'b1;
                m0_data  <= s_data;
                m0_last  <= s_last;
            end else if (m0_ready) begin
                m0_valid <= 1'b0;
            end
            if (load1) begin
                m1_valid <= 1'b1;
                m1_data  <= s_data;
                m1_last  <= s_last;
            end else if (m1_ready) begin
                m1_valid <= 1'b0;
            end
            if (accept) begin
                unique case (state)
                    StIdle: begin
                        if (!s_last) begin
                            state <= sel ? StLock1 : StLock0;
                        end
                    end
                    StLock0, StLock1: begin
                        if (s_last) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_cnt <= '0;
            m1_cnt <= '0;
        end else begin
            if (m0_valid && m0_ready) begin
                m0_cnt <= m0_cnt + 16'd1;
            end
            if (m1_valid && m1_ready) begin
                m1_cnt <= m1_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
